// File: rtl/twdl_mult_cta.sv
// Twiddle multiplier for a two-lane radix datapath: lane A times W^n, lane B times W^3n,
// with input framing checks, a delay line that meets the twiddle generator, and a 3-stage multiply.
module twdl_mult_cta #(
    parameter int wData = 16,
    parameter int wTwdl = 16,
    parameter int DLY   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic                    din_sop,
    input  logic                    din_eop,
    input  logic signed [wData-1:0] din_real_a,
    input  logic signed [wData-1:0] din_imag_a,
    input  logic signed [wData-1:0] din_real_b,
    input  logic signed [wData-1:0] din_imag_b,
    output logic                    twdl_sop,
    input  logic signed [wTwdl-1:0] tw_real_1,
    input  logic signed [wTwdl-1:0] tw_imag_1,
    input  logic signed [wTwdl-1:0] tw_real_3,
    input  logic signed [wTwdl-1:0] tw_imag_3,
    output logic                    dout_valid,
    output logic                    dout_sop,
    output logic                    dout_eop,
    output logic signed [wData-1:0] dout_real_a,
    output logic signed [wData-1:0] dout_imag_a,
    output logic signed [wData-1:0] dout_real_b,
    output logic signed [wData-1:0] dout_imag_b,
    output logic                    ovf,
    output logic                    frm_err
);

    localparam int PW   = wData + wTwdl;
    localparam int SW   = PW + 1;
    localparam int FRAC = 14;
    localparam int DW   = 3 + 4 * wData;

    localparam logic signed [SW-1:0] RND_ADD = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [SW-1:0] MAXV    = {{(SW-wData+1){1'b0}}, {(wData-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV    = ~MAXV;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t            state_q, state_d;
    logic              frm_err_q, frm_err_d;
    logic              twdl_sop_q, twdl_sop_d;
    logic              eop_acc;

    logic [DW-1:0]     dl_q [DLY];
    logic [DW-1:0]     dl_d [DLY];
    logic [DW-1:0]     tap;

    logic signed [wData-1:0] t_ar, t_ai, t_br, t_bi;
    logic signed [PW-1:0]    p1_q [8];
    logic signed [PW-1:0]    p1_d [8];
    logic signed [SW-1:0]    p2_q [4];
    logic signed [SW-1:0]    p2_d [4];
    logic signed [wData-1:0] dout_q [4];
    logic signed [wData-1:0] dout_d [4];
    logic [2:0]              st_p1_q, st_p1_d;
    logic [2:0]              st_p2_q, st_p2_d;
    logic [2:0]              st_p3_q, st_p3_d;
    logic [3:0]              sat;
    logic                    ovf_q, ovf_d;

    // Framing: an eop only travels down the pipe when it closes a real frame.
    always_comb begin
        state_d    = state_q;
        frm_err_d  = 1'b0;
        eop_acc    = 1'b0;
        twdl_sop_d = din_valid & din_sop;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    if (din_sop) begin
                        eop_acc = din_eop;
                        if (!din_eop) state_d = IN_FRAME;
                    end else if (din_eop) begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            IN_FRAME: begin
                if (!din_valid) begin
                    frm_err_d = 1'b1;
                end else begin
                    if (din_sop) frm_err_d = 1'b1;
                    eop_acc = din_eop;
                    if (din_eop) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dl_d[0] = {din_valid, din_valid & din_sop, eop_acc,
                      din_real_a, din_imag_a, din_real_b, din_imag_b};

    for (genvar gi = 1; gi < DLY; gi++) begin : g_dl
        assign dl_d[gi] = dl_q[gi-1];
    end

    assign tap  = dl_q[DLY-1];
    assign t_ar = tap[4*wData-1 -: wData];
    assign t_ai = tap[3*wData-1 -: wData];
    assign t_br = tap[2*wData-1 -: wData];
    assign t_bi = tap[wData-1   -: wData];

    always_comb begin
        st_p1_d = tap[DW-1 -: 3];
        st_p2_d = st_p1_q;
        st_p3_d = st_p2_q;
        p1_d[0] = PW'(t_ar) * PW'(tw_real_1);
        p1_d[1] = PW'(t_ai) * PW'(tw_imag_1);
        p1_d[2] = PW'(t_ar) * PW'(tw_imag_1);
        p1_d[3] = PW'(t_ai) * PW'(tw_real_1);
        p1_d[4] = PW'(t_br) * PW'(tw_real_3);
        p1_d[5] = PW'(t_bi) * PW'(tw_imag_3);
        p1_d[6] = PW'(t_br) * PW'(tw_imag_3);
        p1_d[7] = PW'(t_bi) * PW'(tw_real_3);
        p2_d[0] = SW'(p1_q[0]) - SW'(p1_q[1]);
        p2_d[1] = SW'(p1_q[2]) + SW'(p1_q[3]);
        p2_d[2] = SW'(p1_q[4]) - SW'(p1_q[5]);
        p2_d[3] = SW'(p1_q[6]) + SW'(p1_q[7]);
    end

    // Round half toward +inf, then clamp; data is zeroed whenever the strobe is low.
    always_comb begin
        logic signed [SW-1:0] rnd;
        logic signed [SW-1:0] shf;
        for (int i = 0; i < 4; i++) begin
            rnd    = p2_q[i] + RND_ADD;
            shf    = rnd >>> FRAC;
            sat[i] = 1'b0;
            if (shf > MAXV) begin
                shf    = MAXV;
                sat[i] = 1'b1;
            end else if (shf < MINV) begin
                shf    = MINV;
                sat[i] = 1'b1;
            end
            dout_d[i] = st_p2_q[2] ? shf[wData-1:0] : '0;
        end
        ovf_d = (st_p2_q[1] ? 1'b0 : ovf_q) | (st_p2_q[2] & (|sat));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frm_err_q  <= 1'b0;
            twdl_sop_q <= 1'b0;
            ovf_q      <= 1'b0;
            st_p1_q    <= '0;
            st_p2_q    <= '0;
            st_p3_q    <= '0;
            for (int i = 0; i < DLY; i++) dl_q[i] <= '0;
            for (int i = 0; i < 8; i++) p1_q[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                p2_q[i]   <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            frm_err_q  <= frm_err_d;
            twdl_sop_q <= twdl_sop_d;
            ovf_q      <= ovf_d;
            st_p1_q    <= st_p1_d;
            st_p2_q    <= st_p2_d;
            st_p3_q    <= st_p3_d;
            for (int i = 0; i < DLY; i++) dl_q[i] <= dl_d[i];
            for (int i = 0; i < 8; i++) p1_q[i] <= p1_d[i];
            for (int i = 0; i < 4; i++) begin
                p2_q[i]   <= p2_d[i];
                dout_q[i] <= dout_d[i];
            end
        end
    end

    assign twdl_sop    = twdl_sop_q;
    assign frm_err     = frm_err_q;
    assign ovf         = ovf_q;
    assign dout_valid  = st_p3_q[2];
    assign dout_sop    = st_p3_q[1];
    assign dout_eop    = st_p3_q[0];
    assign dout_real_a = dout_q[0];
    assign dout_imag_a = dout_q[1];
    assign dout_real_b = dout_q[2];
    assign dout_imag_b = dout_q[3];

endmodule
